// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a framed byte stream
// (LEN_HI, LEN_LO, N big-endian 32-bit words, XOR checksum byte) and
// holds the CPU in reset until a load completes with a matching checksum.
module imem_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int unsigned MAX_WORDS = 2 ** (ADDR_WIDTH - 2);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            len_hi_q, len_hi_d;
   logic [15:0]           wl_q, wl_d;        // words still to write
   logic [1:0]            cnt_q, cnt_d;      // bytes of current word consumed
   logic [31:0]           word_q, word_d;    // word being assembled
   logic [31:0]           wdata_q, wdata_d;  // last completed word, held for the write port
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            csum_q, csum_d;
   logic [15:0]           len_n;

   // Frame length as soon as the low byte is on the bus
   assign len_n = {len_hi_q, in_data};

   // Status outputs decode straight from the state register
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign busy       = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA) ||
                       (state_q == S_WRITE)  || (state_q == S_CSUM);
   assign done       = (state_q == S_DONE);
   assign error      = (state_q == S_ERROR);
   assign cpu_reset  = (state_q != S_DONE);

   // State and datapath registers, synchronous reset aborts any load in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         len_hi_q <= '0;
         wl_q     <= '0;
         cnt_q    <= '0;
         word_q   <= '0;
         wdata_q  <= '0;
         addr_q   <= '0;
         csum_q   <= '0;
      end else begin
         state_q  <= state_d;
         len_hi_q <= len_hi_d;
         wl_q     <= wl_d;
         cnt_q    <= cnt_d;
         word_q   <= word_d;
         wdata_q  <= wdata_d;
         addr_q   <= addr_d;
         csum_q   <= csum_d;
      end
   end

   // Next-state, handshake and write-strobe logic
   always_comb begin
      state_d  = state_q;
      len_hi_d = len_hi_q;
      wl_d     = wl_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      wdata_d  = wdata_q;
      addr_d   = addr_q;
      csum_d   = csum_q;
      in_ready = 1'b0;
      imem_we  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_LEN_HI;
               csum_d  = '0;
               addr_d  = '0;
               cnt_d   = '0;
            end
         end
         S_LEN_HI: begin
            in_ready = 1'b1;
            if (in_valid) begin
               len_hi_d = in_data;
               csum_d   = csum_q ^ in_data;
               state_d  = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            in_ready = 1'b1;
            if (in_valid) begin
               csum_d = csum_q ^ in_data;
               cnt_d  = '0;
               wl_d   = len_n;
               // Oversize frames are rejected before any write touches memory
               if (32'(len_n) > MAX_WORDS) state_d = S_ERROR;
               else if (len_n == 16'd0)    state_d = S_CSUM;
               else                        state_d = S_DATA;
            end
         end
         S_DATA: begin
            in_ready = 1'b1;
            if (in_valid) begin
               csum_d = csum_q ^ in_data;
               word_d = {word_q[23:0], in_data};
               cnt_d  = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  wdata_d = {word_q[23:0], in_data};
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            imem_we = 1'b1;
            addr_d  = addr_q + ADDR_WIDTH'(4);
            wl_d    = wl_q - 16'd1;
            state_d = (wl_q == 16'd1) ? S_CSUM : S_DATA;
         end
         S_CSUM: begin
            in_ready = 1'b1;
            if (in_valid) state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The datapath only reads instruction memory; this block fills it.
- Receives a framed byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them to consecutive word-aligned byte addresses.
- Holds the CPU in reset until a load completes with a good checksum.
- Sits between the host/debug byte source and the instruction memory write port, alongside the single-cycle datapath.

Parameters:
- ADDR_WIDTH, 8, byte-address width of instruction memory. Capacity MAX_WORDS = 2^(ADDR_WIDTH-2), which is 64 at the default.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load
- in_valid  in  1  byte source has a byte on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_WIDTH  byte address of the write, bits [1:0] always 0
- imem_wdata  out  32  instruction word to write
- cpu_reset  out  1  hold-reset to the datapath, 1 = CPU held in reset
- busy  out  1  load in progress
- done  out  1  last load succeeded
- error  out  1  last load failed

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, busy=0, done=0, error=0. Checksum, word count and byte counter are all cleared.
- Reset mid-load aborts the load immediately. There is no partial completion.
- Frame format, in order:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N words of 4 bytes each, MSB first.
  - One CSUM byte.
- A byte is consumed on a rising edge only when in_valid && in_ready.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, CSUM, DONE, ERROR.
- IDLE / DONE / ERROR, with start=1: next state is LEN_HI.
  - busy=1, done=0, error=0, cpu_reset=1.
  - Checksum cleared, imem_addr=0.
- start is ignored in every other state.
- in_ready:
  - 1 in LEN_HI, LEN_LO, DATA and CSUM.
  - 0 in IDLE, WRITE, DONE and ERROR.
- Running checksum: XOR of every consumed byte, including the length bytes and excluding the CSUM byte.
- LEN_LO consumed, next state depends on N:
  - N > MAX_WORDS: ERROR, no writes issued.
  - N = 0: CSUM.
  - Otherwise: DATA, words_left = N.
- DATA:
  - Each consumed byte shifts in: word = {word[23:0], in_data}.
  - The 4th consumed byte moves the block to WRITE.
- WRITE (exactly one cycle):
  - imem_we=1, imem_wdata = assembled word, imem_addr = current address.
  - Next cycle: imem_we=0, imem_addr += 4, words_left -= 1.
  - Next state is CSUM if words_left was 1, otherwise DATA.
- Throughput: 5 cycles per word when in_valid is held high.
- Address rule: the last word of a full load (N = MAX_WORDS) lands at 2^ADDR_WIDTH - 4. The address never wraps within a load.
- CSUM byte consumed:
  - Byte == running checksum: DONE, with done=1, busy=0, cpu_reset=0.
  - Otherwise: ERROR, with error=1, busy=0, cpu_reset=1.
- Words already written before an ERROR stay in memory. The loader does not clean them up.
- imem_wdata and imem_addr hold their last values while imem_we=0.
- start in DONE re-asserts cpu_reset on the next cycle.

Test Plan:
1. Good 2-word load.
   - Stimulus: start, then bytes 00 02 20 08 00 05 01 2A 30 20 14 with in_valid held high.
   - Required: imem_we pulses at addr 0x00 with data 0x20080005, then at addr 0x04 with data 0x012A3020.
   - Then done=1, busy=0, cpu_reset=0, error=0.
2. Bad checksum.
   - Stimulus: same stream with final byte 15.
   - Required: both writes occur; then error=1, done=0, cpu_reset stays 1.
3. Oversize length.
   - Stimulus: start, bytes 00 41 (65 words, ADDR_WIDTH=8).
   - Required: ERROR the cycle after LEN_LO, imem_we never asserted, in_ready=0 afterwards.
4. Zero length.
   - Stimulus: start, bytes 00 00 00.
   - Required: no imem_we, done=1, cpu_reset=0.
5. Handshake gaps.
   - Stimulus: test 1 stream with in_valid deasserted on alternate cycles, and in_valid held high during each WRITE cycle.
   - Required: identical writes and result; no byte is consumed while in_ready=0.
   - A start pulse mid-load is ignored.
6. Reset mid-load.
   - Stimulus: assert reset after 2 DATA bytes.
   - Required: all outputs return to reset values next cycle.
   - A fresh test-1 load then completes with done=1.
